// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative 32-iteration shift-add multiplier / restoring divider
// with Hi/Lo result registers, MTHI/MTLO writes and a Busy/Done handshake.
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  input  logic             hi_write_i,
  input  logic             lo_write_i,
  input  logic [WIDTH-1:0] write_data_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Operand magnitudes for signed ops (op_i[0]==0 means signed).
  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;

  assign a_neg = ~op_i[0] & operand_a_i[WIDTH-1];
  assign b_neg = ~op_i[0] & operand_b_i[WIDTH-1];
  assign a_mag = a_neg ? (~operand_a_i + 1'b1) : operand_a_i;
  assign b_mag = b_neg ? (~operand_b_i + 1'b1) : operand_b_i;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_cand;
  logic [WIDTH:0]       div_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix, a_orig;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
  // Remainder shifted left with the next dividend bit brought in.
  assign div_cand = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff = div_cand - {1'b0, b_q};
  assign div_ge   = ~div_diff[WIDTH];

  assign prod_fix = neg_res_q ? (~acc_q + 1'b1) : acc_q;
  assign quo_fix  = neg_res_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  assign a_orig   = neg_rem_q ? (~a_q + 1'b1) : a_q;

  always_comb begin
    state_d   = state_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (hi_write_i) hi_d = write_data_i;
        if (lo_write_i) lo_d = write_data_i;
        if (start_i) begin
          state_d   = RUN;
          is_div_d  = op_i[1];
          a_d       = a_mag;
          b_d       = b_mag;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          cnt_d     = '0;
          acc_d     = op_i[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (is_div_q) begin
          acc_d = {(div_ge ? div_diff[WIDTH-1:0] : div_cand[WIDTH-1:0]),
                   acc_q[WIDTH-2:0], div_ge};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(WIDTH-1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        if (!is_div_q) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (b_q == '0) begin
          // Divide by zero reports all-ones quotient and the original dividend.
          hi_d = a_orig;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == FIX);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: driver pushes expected Hi/Lo, monitor checks on Done.
`default_nettype none

module tb_mult_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = 2'b00;
  logic [31:0] operand_a_i = '0;
  logic [31:0] operand_b_i = '0;
  logic        hi_write_i = 1'b0;
  logic        lo_write_i = 1'b0;
  logic [31:0] write_data_i = '0;
  logic [31:0] hi_o, lo_o;
  logic        busy_o, done_o;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
    .operand_a_i(operand_a_i), .operand_b_i(operand_b_i),
    .hi_write_i(hi_write_i), .lo_write_i(lo_write_i), .write_data_i(write_data_i),
    .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: pops one expected result per Done pulse.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (done_o === 1'b1 && busy_o === 1'b1) begin
        checks++; errors++;
        $display("FAIL done_with_busy: got busy=1 expected busy=0");
      end
      if (done_o === 1'b1) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected done=0");
        end else begin
          e = sb.pop_front();
          check32({e.name, "_hi"}, hi_o, e.hi);
          check32({e.name, "_lo"}, lo_o, e.lo);
          check32({e.name, "_latency"}, 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    int n = 0;
    do begin
      @(negedge clk_i);
      n++;
    end while (busy_o !== 1'b0 && n < 100);
    if (busy_o !== 1'b0) begin
      checks++; errors++;
      $display("FAIL %s_wait_idle: got busy=%b expected 0", name, busy_o);
    end
    start_i = 1'b1; op_i = op; operand_a_i = a; operand_b_i = b;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    e.hi = ehi; e.lo = elo; e.due = cyc + 33; e.name = name;
    sb.push_back(e);
    check32({name, "_busy"}, {31'b0, busy_o}, 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL result_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk_i);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random inputs.
    rst_ni = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      start_i = 1'($urandom); op_i = 2'($urandom);
      operand_a_i = $urandom; operand_b_i = $urandom;
      hi_write_i = 1'($urandom); lo_write_i = 1'($urandom); write_data_i = $urandom;
    end
    @(negedge clk_i);
    check32("rst_hi", hi_o, 32'h0);
    check32("rst_lo", lo_o, 32'h0);
    check32("rst_busy", {31'b0, busy_o}, 32'h0);
    check32("rst_done", {31'b0, done_o}, 32'h0);
    start_i = 0; hi_write_i = 0; lo_write_i = 0;
    rst_ni = 1'b1;
    @(negedge clk_i);

    run_op("mult_neg",   2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
    wait_idle();
    run_op("multu_max",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
    wait_idle();
    run_op("mult_min",   2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    wait_idle();
    run_op("div_m7_2",   2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    wait_idle();
    run_op("div_7_m2",   2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    wait_idle();
    run_op("div_ovf",    2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    wait_idle();
    run_op("divu_zero",  2'b11, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF);
    wait_idle();
    run_op("div_zero",   2'b10, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF);
    wait_idle();

    // Back-to-back: second start lands in the Done cycle of the first.
    run_op("b2b_divu",   2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF);
    run_op("b2b_multu",  2'b01, 32'd6,        32'd7,        32'h00000000, 32'd42);
    wait_idle();

    // Interference while busy.
    run_op("interfere",  2'b01, 32'h00010000, 32'h00030005, 32'h00000003, 32'h00050000);
    repeat (10) begin
      @(negedge clk_i);
      start_i = ~start_i; op_i = 2'($urandom);
      operand_a_i = $urandom; operand_b_i = $urandom;
      hi_write_i = ~hi_write_i; write_data_i = 32'hDEAD;
    end
    @(negedge clk_i);
    start_i = 0; hi_write_i = 0;
    wait_idle();
    lo_write_i = 1'b1; write_data_i = 32'h1234;
    @(posedge clk_i);
    #1;
    lo_write_i = 1'b0;
    check32("mtlo_lo", lo_o, 32'h1234);
    check32("mtlo_hi", hi_o, 32'h3);

    // Mid-operation reset: no Done, outputs cleared immediately.
    @(negedge clk_i);
    start_i = 1'b1; op_i = 2'b01; operand_a_i = 32'h12345678; operand_b_i = 32'h9;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check32("midrst_hi", hi_o, 32'h0);
    check32("midrst_lo", lo_o, 32'h0);
    check32("midrst_busy", {31'b0, busy_o}, 32'h0);
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (40) @(negedge clk_i);
    check32("midrst_nodone_lo", lo_o, 32'h0);
    run_op("after_rst",  2'b00, 32'hFFFFFFF9, 32'h00000006, 32'hFFFFFFFF, 32'hFFFFFFD6);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit placed directly downstream of the register file. It latches the two register read operands, runs a 32-iteration shift-add multiply or restoring divide, and holds the 64-bit result in dedicated Hi/Lo registers for MFHI/MFLO-style readback. A Busy/Done handshake lets the control unit stall the datapath while an operation is in flight.

## Interface
- WIDTH, 32: operand width; Hi and Lo are each WIDTH bits.
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous reset, active-low.
- Start  in  1  request; sampled only in IDLE.
- Op  in  2  operation: 00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
- Operand_a  in  WIDTH  multiplicand or dividend (register file Read_data_1).
- Operand_b  in  WIDTH  multiplier or divisor (register file Read_data_2).
- Hi_write  in  1  load Write_data into Hi (MTHI).
- Lo_write  in  1  load Write_data into Lo (MTLO).
- Write_data  in  WIDTH  data for Hi_write/Lo_write.
- Hi  out  WIDTH  high product or remainder.
- Lo  out  WIDTH  low product or quotient.
- Busy  out  1  high from the edge after acceptance through FIX.
- Done  out  1  one-cycle pulse when Hi/Lo take a new result.

## Operation
- Reset (RST=0, asynchronous): state IDLE, Hi=0, Lo=0, Busy=0, Done=0, counter=0, internal operand latches=0. Reset during RUN/FIX aborts the operation; no partial result is written.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on Start=1.
  - RUN -> FIX after the 32nd iteration, when the counter reaches 31.
  - FIX -> IDLE unconditionally.
- Accept (IDLE, Start=1): latch Op, Operand_a, Operand_b. For signed ops, latch magnitudes plus the result-sign flags. Operand changes after acceptance have no effect.
- Multiply: 64-bit shift-add, one multiplier bit per cycle.
  - FIX negates the 64-bit product if the operand signs differ (signed op only).
  - Hi = product[63:32], Lo = product[31:0].
- Divide: restoring division, one quotient bit per cycle.
  - FIX negates the quotient if the signs differ.
  - FIX gives the remainder the dividend's sign.
  - Lo = quotient, Hi = remainder.
- Divide by zero (both DIV and DIVU): full latency; Lo=32'hFFFFFFFF, Hi=original Operand_a.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0.
- Start while Busy=1: ignored; the in-flight operation is unaffected.
- Hi_write/Lo_write while Busy=1: ignored.
- Hi_write/Lo_write in IDLE: the register updates at the edge.
- Hi_write/Lo_write together with an accepted Start: the write is applied; the later result overwrites it.
- Hi and Lo change only on reset, on an accepted MT write, or on the FIX->IDLE edge.

## Timing
- Edge e0: Start accepted; Busy=1 after e0.
- Edges e1..e32: iterations; state=FIX after e32.
- Edge e33: Hi/Lo updated, Done=1 and Busy=0 for the cycle after e33, state IDLE.
- Result latency: 33 cycles from the accept edge.
- Back-to-back: Start may be asserted in the cycle Done=1 and is accepted at that edge, giving a 34-cycle throughput per operation.
- Done is never high while Busy=1.
- Busy is a registered output; the control unit uses it as a combinational stall.
- No combinational path from any input to any output.

## Test plan
- Reset: hold RST=0 with random inputs -> Hi=0, Lo=0, Busy=0, Done=0.
- MULT: Operand_a=0xFFFFFFFE (-2), Operand_b=0x00000003 -> after 33 cycles, Hi=0xFFFFFFFF, Lo=0xFFFFFFFA, one-cycle Done.
- MULTU: 0xFFFFFFFF × 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- DIV: -7 / 2 -> Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
- DIV boundary case: 0x80000000 / 0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU: 100 / 0 -> Lo=0xFFFFFFFF, Hi=100.
- Interference: during Busy, toggle Start and the operands and pulse Hi_write -> result unchanged. In IDLE, Lo_write with 0x1234 -> Lo=0x1234 next cycle.
- Mid-operation reset: assert RST=0 at iteration 10 -> outputs zero immediately, no Done. A new Start after release yields correct results.
